shift_add_multiplier: RTL



---
 rtl/shift_add_pkg.sv | 20 ++
 rtl/four_bit_rca.sv | 21 ++
 rtl/shift_add_multiplier_rca_chain.sv | 31 +++
 rtl/shift_add_multiplier.sv | 108 ++++++++++
 4 files changed

// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encodings, default width
// and the iteration-counter width helper.
package shift_add_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/four_bit_rca.sv
// Four-bit ripple-carry adder slice, the building block of the upstream adder stage.
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[4];

endmodule

// File: rtl/shift_add_multiplier_rca_chain.sv
// WIDTH-bit adder made of WIDTH/4 chained four_bit_rca slices; keeps the adder
// structure out of the multiplier FSM.
module rca_chain #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NUM_SLICES = WIDTH / 4;

    logic [NUM_SLICES:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        four_bit_rca u_rca (
            .A    (A[4*i +: 4]),
            .B    (B[4*i +: 4]),
            .Cin  (carry[i]),
            .S    (S[4*i +: 4]),
            .Cout (carry[i+1])
        );
    end

    assign Cout = carry[NUM_SLICES];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one conditional add and shift per cycle.
// Optional SHIFT_ADD_ZERO_SKIP_EN: zero operands bypass CALC and finish in one cycle.
module shift_add_multiplier
    import shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t state, state_n;

    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mult;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               accept;
    logic               last;
    logic               skip;
    logic               unused_msb;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign addend = mult[0] ? mcand : '0;

`ifdef SHIFT_ADD_ZERO_SKIP_EN
    assign skip = (A == '0) || (B == '0);
`else
    assign skip = 1'b0;
`endif

    // The shift moves the carry down into acc_hi[WIDTH-1], so the top bit is always zero.
    assign unused_msb = acc_hi[WIDTH];

    rca_chain #(
        .WIDTH (WIDTH)
    ) u_rca_chain (
        .A    (acc_hi[WIDTH-1:0]),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = skip ? DONE : CALC;
            CALC:    if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi <= '0;
            mcand  <= '0;
            mult   <= '0;
            cnt    <= '0;
            P      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= A;
                        mult   <= B;
                        acc_hi <= '0;
                        cnt    <= '0;
                        if (skip) P <= '0;
                    end
                end
                CALC: begin
                    // {acc_hi, mult} <= {cout, sum, mult} >> 1
                    acc_hi <= {1'b0, cout, sum[WIDTH-1:1]};
                    mult   <= {sum[0], mult[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (last) P <= {cout, sum, mult[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule
